vex_input_arbiter: RTL
======================

# vex_input_arbiter

Packet-granular round-robin arbiter that shares the single 32-bit input stream of a vex machine (q_engine `t0` port, or its input FIFO) between up to `NUM_SRC` upstream requesters. A grant is held for a whole packet, delimited by `last`, so packets are never interleaved. A per-packet beat limit truncates runaway packets and drains their remainder. The block sits directly in front of the vex machine top's `t0_*` port, inside the same clock domain.

## Interface
- `NUM_SRC`, default 4: number of requesting sources, range 2..8.
- `WIDTH`, default 32: data width per beat.
- `MAX_BEATS`, default 1024: beats allowed per packet; 0 disables the limit.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `s_data` input `NUM_SRC*WIDTH`: source data; source i is in slice [i*WIDTH +: WIDTH].
- `s_last` input `NUM_SRC`: per-source end of packet.
- `s_valid` input `NUM_SRC`: per-source valid.
- `s_ready` output `NUM_SRC`: per-source ready.
- `i_enable` input `NUM_SRC`: per-source arbitration enable, normally driven from `outside_control`.
- `o_data` output `WIDTH`: to vex `t0_data`.
- `o_last` output 1: to vex `t0_last`.
- `o_valid` output 1: to vex `t0_valid`.
- `o_ready` input 1: from vex `t0_ready`.
- `o_grant_idx` output 3: index of the currently or last granted source.
- `o_busy` output 1: high while in LOCKED or DRAIN.
- `o_overrun` output 1: sticky; set on any truncation, cleared only by `clr_overrun`.
- `clr_overrun` input 1: clears `o_overrun`.
- `o_pkt_count` output 32: packets forwarded, including truncated ones; wraps at 2^32.

## Operation
- States: IDLE, LOCKED, DRAIN.
- IDLE:
  - Candidates are sources with `s_valid & i_enable`.
  - Search starts at `(last_grant+1) mod NUM_SRC` and wraps; the first hit is chosen.
  - The chosen index is registered into `grant`, `last_grant` takes the same value, and the next state is LOCKED.
  - With no candidate, stay in IDLE.
  - All `s_ready` are 0 in IDLE.
- LOCKED:
  - `s_ready[grant] = ~o_valid | o_ready`; every other `s_ready` is 0.
  - An accepted beat (`s_valid[grant] & s_ready[grant]`) loads the output register and increments `beat_cnt`.
  - Accepted beat with `s_last[grant]=1`: `o_pkt_count`+1, `beat_cnt`←0, next state IDLE.
  - Accepted beat with `s_last=0` and `MAX_BEATS≠0` and `beat_cnt == MAX_BEATS-1`:
    - forward the beat with `o_last` forced to 1;
    - set `o_overrun`, `o_pkt_count`+1, `beat_cnt`←0;
    - next state DRAIN.
- DRAIN:
  - `s_ready[grant]=1`; beats are discarded and never reach the output.
  - A discarded beat with `s_last=1` moves the state to IDLE.
- `i_enable` is sampled only in IDLE. Deasserting the enable of the granted source does not abort LOCKED or DRAIN.
- Output register: loaded on accepted beats, holds while `o_valid & ~o_ready`, and clears `o_valid` when it drains with no new beat.
- `o_grant_idx` = `grant`. It is zero-extended when `NUM_SRC ≤ 4`.
- `clr_overrun` and a simultaneous truncation in the same cycle: the set wins.

## Timing
- Reset values:
  - `o_valid`=0, `o_data`=0, `o_last`=0;
  - `s_ready`=0, `o_busy`=0, `o_overrun`=0;
  - `o_pkt_count`=0, `o_grant_idx`=0, `grant`=0;
  - `last_grant`=`NUM_SRC-1`, so source 0 has first priority;
  - state IDLE, `beat_cnt`=0.
- Reset mid-packet discards the output register and the in-flight grant.
- Arbitration takes 1 cycle: a request in IDLE at cycle N gives `s_ready` high at N+1 if the output has space.
- Data latency is 1 cycle: a beat accepted at edge N appears on `o_data`/`o_valid` after edge N.
- Full throughput is 1 beat/clk within a packet while `o_ready`=1.
- Each packet boundary costs exactly 1 IDLE bubble cycle.
- `s_ready` depends combinationally on `o_ready`. There is no combinational path from `s_valid` to `s_ready`.
- `o_pkt_count` and `o_overrun` update on the edge where the qualifying beat is accepted.

## Test plan
- Single source, reset release: source 0 sends 3 beats 0xA0..0xA2 with last on 0xA2, `o_ready`=1 → `o_data` sequence A0, A1, A2 on consecutive cycles starting 2 cycles after `s_valid`; `o_last` only on A2; `o_pkt_count`=1; state back to IDLE.
- Round robin, all 4 sources continuously valid with 2-beat packets → grant order 0,1,2,3,0; no interleaving; one bubble between packets; `o_pkt_count`=5 after 5 packets.
- Backpressure: `o_ready` low for 5 cycles mid-packet → `o_data`/`o_last` stable while held; `s_ready[grant]`=0 while the register is full; no beat lost or duplicated across 20 random stall patterns.
- Overrun with `MAX_BEATS`=4: source 2 sends 7 beats, last on beat 7 → beats 1–4 forwarded with `o_last` on beat 4; beats 5–7 consumed and dropped; `o_overrun`=1; `clr_overrun` pulse → 0.
- Enable mask: `i_enable`=4'b1010 with all sources valid → only sources 1 and 3 granted, alternating. Clearing bit 1 mid-packet of source 1 lets that packet complete, after which source 1 is no longer granted.
- Reset mid-packet: assert `reset` during beat 2 of a 4-beat packet → next cycle `o_valid`=0, `s_ready`=0, `o_pkt_count`=0; after release source 0 wins first.

Source files
------------

// File: rtl/vex_input_arbiter.sv
// Packet-granular round-robin arbiter feeding the vex t0 input port.
// A grant is held for a whole packet; oversized packets are truncated and their tail drained.
module vex_input_arbiter #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BEATS = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] s_data,
  input  logic [NUM_SRC-1:0]       s_last,
  input  logic [NUM_SRC-1:0]       s_valid,
  output logic [NUM_SRC-1:0]       s_ready,
  input  logic [NUM_SRC-1:0]       i_enable,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [2:0]               o_grant_idx,
  output logic                     o_busy,
  output logic                     o_overrun,
  input  logic                     clr_overrun,
  output logic [31:0]              o_pkt_count
);

  localparam int unsigned IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CNT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam bit          LIMIT_EN = (MAX_BEATS != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCKED,
    ST_DRAIN
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] last_grant_q;
  logic [CNT_W-1:0] beat_cnt_q;

  logic [WIDTH-1:0] src_data [NUM_SRC];
  logic [NUM_SRC-1:0] cand;
  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  int unsigned        cand_idx;
  logic               accept;
  logic               in_last;
  logic               fwd;
  logic               trunc;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_data[g] = s_data[g*WIDTH +: WIDTH];
  end

  // Round-robin search starting just after the previous grant
  always_comb begin
    cand     = s_valid & i_enable;
    pick     = '0;
    pick_vld = 1'b0;
    cand_idx = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand_idx = (32'(last_grant_q) + k) % NUM_SRC;
      if (!pick_vld && cand[IDX_W'(cand_idx)]) begin
        pick     = IDX_W'(cand_idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Only the granted source sees ready; in DRAIN its beats are swallowed
  always_comb begin
    s_ready = '0;
    if (state_q == ST_LOCKED) begin
      s_ready[grant_q] = ~o_valid | o_ready;
    end else if (state_q == ST_DRAIN) begin
      s_ready[grant_q] = 1'b1;
    end
  end

  assign accept  = s_valid[grant_q] & s_ready[grant_q];
  assign in_last = s_last[grant_q];
  assign fwd     = (state_q == ST_LOCKED) && accept;
  assign trunc   = LIMIT_EN && fwd && !in_last &&
                   (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

  assign o_grant_idx = 3'(grant_q);
  assign o_busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_SRC - 1);
      beat_cnt_q   <= '0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_last       <= 1'b0;
      o_overrun    <= 1'b0;
      o_pkt_count  <= '0;
    end else begin
      if (fwd) begin
        o_valid <= 1'b1;
        o_data  <= src_data[grant_q];
        o_last  <= in_last | trunc;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end

      // A truncation in the same cycle as a clear keeps the flag set
      if (trunc) begin
        o_overrun <= 1'b1;
      end else if (clr_overrun) begin
        o_overrun <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_q      <= pick;
            last_grant_q <= pick;
            state_q      <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (accept) begin
            if (in_last || trunc) begin
              beat_cnt_q  <= '0;
              o_pkt_count <= o_pkt_count + 32'd1;
              state_q     <= in_last ? ST_IDLE : ST_DRAIN;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (accept && in_last) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
